ps2_kbd_ctrl: RTL and testbench
===============================

Name: ps2_kbd_ctrl

Overview:
- Sits directly downstream of the PS/2 port engine and sits between that engine and the CPU-visible register file.
- Queues received scan-codes in a byte FIFO for the CPU.
- Serialises host commands (e.g. 0xED set-LEDs, 0xFF reset) to the port.
- Consumes the device's 0xFA/0xFE responses and retries on NACK, resend request or timeout.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes.
- MAX_RETRY, 3, max re-sends of one command after the first attempt.
- TXACK_TIMEOUT_US, 15000, max µs from command issue to tx_acked_i/tx_errd_i.
- RESP_TIMEOUT_US, 20000, max µs from tx_acked_i to device response byte.

Ports:
- clk6x  in  1  system clock, 48 MHz.
- resetn  in  1  asynchronous active-low reset.
- ck1us  in  1  1 µs strobe, 1 cycle wide.
- code_rx_i  in  8  byte from port.
- code_rx_v_i  in  1  byte valid pulse.
- port_busy_i  in  1  port busy; a command is accepted only while 0.
- tx_acked_i  in  1  port: command byte line-level ACKed.
- tx_errd_i  in  1  port: command byte line-level NACKed.
- cmd_tx_o  out  8  command byte to port.
- cmd_tx_v_o  out  1  command send pulse.
- rd_data_o  out  8  FIFO head (first-word fall-through); 0x00 when empty.
- rd_empty_o  out  1  FIFO empty.
- rd_pop_i  in  1  pop head.
- fifo_count_o  out  DEPTH_LOG2+1  occupancy.
- ovf_o  out  1  sticky overflow flag.
- ovf_clr_i  in  1  clear ovf_o.
- host_cmd_i  in  8  command byte from CPU.
- host_cmd_v_i  in  1  command request pulse.
- host_cmd_busy_o  out  1  command engine not idle.
- host_cmd_done_o  out  1  pulse: device answered 0xFA.
- host_cmd_err_o  out  1  pulse: retries exhausted.

Behaviour:
- Reset, asynchronous:
  - All outputs 0, FIFO pointers and count 0, ovf_o=0.
  - rd_empty_o=1, FSM=C_IDLE, retry counter 0, timer stopped.
  - Reset mid-command abandons the command silently, with no done/err pulse.
- FIFO:
  - Push = code_rx_v_i && !consumed. "Consumed" means the FSM is in C_WAIT_RESP and the byte is 0xFA or 0xFE.
  - Push when full: byte dropped, ovf_o<=1 next cycle.
  - Pop when empty: ignored.
  - Push and pop in the same cycle: both performed, count unchanged, including at full and empty.
  - rd_data_o/rd_empty_o/fifo_count_o reflect the new state one cycle after the push/pop edge.
  - Pointers wrap modulo 2**DEPTH_LOG2.
  - ovf_clr_i clears ovf_o. If it coincides with an overflowing push, set wins.
- Timer: 15-bit down counter decremented on ck1us while running; "expired" = reaches 0.
- Command FSM:
  - C_IDLE: host_cmd_busy_o=0. On host_cmd_v_i, latch host_cmd_i into cmd_tx_o, retry<=0 → C_ISSUE. host_cmd_v_i in any other state is ignored.
  - C_ISSUE: when port_busy_i==0, pulse cmd_tx_v_o for exactly 1 cycle, load timer=TXACK_TIMEOUT_US → C_WAIT_TXACK.
  - C_WAIT_TXACK:
    - tx_acked_i → load timer=RESP_TIMEOUT_US → C_WAIT_RESP.
    - tx_errd_i or timer expiry → C_RETRY.
    - This state also covers the case where the port drops the pulse because an RX start raced it.
  - C_WAIT_RESP:
    - code_rx_v_i with 0xFA → pulse host_cmd_done_o → C_IDLE.
    - 0xFE → C_RETRY.
    - Timer expiry → C_RETRY.
    - Other bytes are queued in the FIFO and the FSM stays.
  - C_RETRY: if retry==MAX_RETRY, pulse host_cmd_err_o → C_IDLE; else retry<=retry+1 → C_ISSUE.
  - Simultaneous tx_acked_i and tx_errd_i: tx_errd_i wins.
- cmd_tx_o holds the latched byte until the next accepted command.
- Latency: command accepted in C_IDLE → cmd_tx_v_o no earlier than 1 cycle later.

Decomposition:
- Package ps2_pkg:
  - PS2_ACK=8'hFA, PS2_RESEND=8'hFE.
  - Command FSM state encoding (C_IDLE, C_ISSUE, C_WAIT_TXACK, C_WAIT_RESP, C_RETRY).
  - Default timeout constants.
- Sub-module ps2_byte_fifo: synchronous FWFT FIFO with push/pop/full/empty/count/overflow, parameterised by DEPTH_LOG2. The controller instantiates it.

Test Plan:
- Push 0x1C,0xF0,0x1C with no pops → count=3, rd_data_o=0x1C; three pops yield 0x1C,0xF0,0x1C, then rd_empty_o=1 and rd_data_o=0x00.
- Push 17 bytes (DEPTH_LOG2=4) → count=16, ovf_o=1, 17th byte lost. Push+pop at full → count stays 16. ovf_clr_i → ovf_o=0.
- host_cmd 0xED, port_busy_i=1 for 50 cycles → cmd_tx_v_o held off; busy drops → single pulse with cmd_tx_o=0xED. tx_acked_i then rx 0xFA → host_cmd_done_o pulse, 0xFA not in FIFO.
- Command 0xFF answered with 0xFE three times, then 0xFA → 4 cmd_tx_v_o pulses, host_cmd_done_o once, FIFO empty.
- Command with tx_errd_i on every attempt → 4 pulses (MAX_RETRY=3), then host_cmd_err_o pulse, host_cmd_busy_o=0.
- During C_WAIT_RESP rx 0x1C then 0xFA → 0x1C queued, done pulse. Assert resetn=0 mid-C_WAIT_TXACK → all outputs 0 immediately, no done/err after release.

Source files
------------

// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared constants, FSM state encoding and a small byte classifier
// for the PS/2 keyboard controller.
package ps2_pkg;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int TXACK_TIMEOUT_US_DEF = 15000;
  localparam int RESP_TIMEOUT_US_DEF  = 20000;
  localparam int TIMER_W              = 15;

  typedef enum logic [2:0] {
    C_IDLE       = 3'd0,
    C_ISSUE      = 3'd1,
    C_WAIT_TXACK = 3'd2,
    C_WAIT_RESP  = 3'd3,
    C_RETRY      = 3'd4
  } cmd_state_e;

  // True for the two device responses the command engine swallows.
  function automatic logic is_resp_byte(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Bus bundle between the keyboard controller, the PS/2 port engine
// and the CPU register file. slave = controller side, master = driver side.
interface ps2_kbd_ctrl_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          code_rx_i;
  logic                code_rx_v_i;
  logic                port_busy_i;
  logic                tx_acked_i;
  logic                tx_errd_i;
  logic [7:0]          cmd_tx_o;
  logic                cmd_tx_v_o;
  logic [7:0]          rd_data_o;
  logic                rd_empty_o;
  logic                rd_pop_i;
  logic [DEPTH_LOG2:0] fifo_count_o;
  logic                ovf_o;
  logic                ovf_clr_i;
  logic [7:0]          host_cmd_i;
  logic                host_cmd_v_i;
  logic                host_cmd_busy_o;
  logic                host_cmd_done_o;
  logic                host_cmd_err_o;

  modport slave (
    input  code_rx_i, code_rx_v_i, port_busy_i, tx_acked_i, tx_errd_i,
    input  rd_pop_i, ovf_clr_i, host_cmd_i, host_cmd_v_i,
    output cmd_tx_o, cmd_tx_v_o, rd_data_o, rd_empty_o, fifo_count_o,
    output ovf_o, host_cmd_busy_o, host_cmd_done_o, host_cmd_err_o
  );

  modport master (
    output code_rx_i, code_rx_v_i, port_busy_i, tx_acked_i, tx_errd_i,
    output rd_pop_i, ovf_clr_i, host_cmd_i, host_cmd_v_i,
    input  cmd_tx_o, cmd_tx_v_o, rd_data_o, rd_empty_o, fifo_count_o,
    input  ovf_o, host_cmd_busy_o, host_cmd_done_o, host_cmd_err_o
  );
endinterface

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO with sticky overflow flag.
// A simultaneous push and pop is always honoured, even when full or empty.
module ps2_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic                pop,
  input  logic                ovf_clr,
  output logic [7:0]          rd_data,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                ovf
);
  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] ONE_C = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_P = DEPTH_LOG2'(1);

  logic [7:0]            mem_r [0:(1 << DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  ovf_r;
  logic                  full_s, empty_s, do_push_s, do_pop_s, ovf_set_s;

  assign full_s    = (count_r == DEPTH);
  assign empty_s   = (count_r == {(DEPTH_LOG2+1){1'b0}});
  // A pop paired with a push frees (or supplies) the slot, so both proceed.
  assign do_push_s = push && (!full_s || pop);
  assign do_pop_s  = pop && (!empty_s || push);
  assign ovf_set_s = push && full_s && !pop;

  assign rd_data = empty_s ? 8'h00 : mem_r[rd_ptr_r];
  assign empty   = empty_s;
  assign count   = count_r;
  assign ovf     = ovf_r;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2+1){1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + ONE_P;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + ONE_P;
      if (do_push_s && !do_pop_s)      count_r <= count_r + ONE_C;
      else if (do_pop_s && !do_push_s) count_r <= count_r - ONE_C;
      if (ovf_set_s)    ovf_r <= 1'b1;
      else if (ovf_clr) ovf_r <= 1'b0;
    end
  end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: queues scan-codes for the CPU and runs the
// host-command engine (issue, wait for line ACK, wait for 0xFA, retry).
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2       = 4,
  parameter int MAX_RETRY        = 3,
  parameter int TXACK_TIMEOUT_US = TXACK_TIMEOUT_US_DEF,
  parameter int RESP_TIMEOUT_US  = RESP_TIMEOUT_US_DEF
) (
  input logic             clk6x,
  input logic             resetn,
  input logic             ck1us,
  ps2_kbd_ctrl_if.slave   bus
);
  localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  cmd_state_e          state_r, state_n;
  logic [7:0]          cmd_r, cmd_n;
  logic [RETRY_W-1:0]  retry_r, retry_n;
  logic [TIMER_W-1:0]  timer_r, timer_n;
  logic                run_r, run_n;
  logic                tx_v_r, tx_v_n, done_r, done_n, err_r, err_n;
  logic                consumed_s, push_s, expired_s;

  // 0xFA/0xFE arriving while a response is awaited belong to the engine.
  assign consumed_s = (state_r == C_WAIT_RESP) && bus.code_rx_v_i
                      && is_resp_byte(bus.code_rx_i);
  assign push_s     = bus.code_rx_v_i && !consumed_s;
  assign expired_s  = run_r && (timer_r == {TIMER_W{1'b0}});

  ps2_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (clk6x),
    .rst_n     (resetn),
    .push      (push_s),
    .push_data (bus.code_rx_i),
    .pop       (bus.rd_pop_i),
    .ovf_clr   (bus.ovf_clr_i),
    .rd_data   (bus.rd_data_o),
    .empty     (bus.rd_empty_o),
    .count     (bus.fifo_count_o),
    .ovf       (bus.ovf_o)
  );

  assign bus.cmd_tx_o        = cmd_r;
  assign bus.cmd_tx_v_o      = tx_v_r;
  assign bus.host_cmd_busy_o = (state_r != C_IDLE);
  assign bus.host_cmd_done_o = done_r;
  assign bus.host_cmd_err_o  = err_r;

  // Command engine state, latched byte, retry count, timer and output pulses.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_r <= C_IDLE;
      cmd_r   <= 8'h00;
      retry_r <= {RETRY_W{1'b0}};
      timer_r <= {TIMER_W{1'b0}};
      run_r   <= 1'b0;
      tx_v_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cmd_r   <= cmd_n;
      retry_r <= retry_n;
      timer_r <= timer_n;
      run_r   <= run_n;
      tx_v_r  <= tx_v_n;
      done_r  <= done_n;
      err_r   <= err_n;
    end
  end

  // Next-state logic; pulses default low, timer counts down on the 1 us strobe.
  always_comb begin
    state_n = state_r;
    cmd_n   = cmd_r;
    retry_n = retry_r;
    run_n   = run_r;
    tx_v_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (run_r && ck1us && !expired_s) timer_n = timer_r - TIMER_W'(1);
    else                              timer_n = timer_r;
    case (state_r)
      C_IDLE: begin
        run_n = 1'b0;
        if (bus.host_cmd_v_i) begin
          cmd_n   = bus.host_cmd_i;
          retry_n = {RETRY_W{1'b0}};
          state_n = C_ISSUE;
        end else begin
          state_n = C_IDLE;
        end
      end
      C_ISSUE: begin
        if (!bus.port_busy_i) begin
          tx_v_n  = 1'b1;
          timer_n = TIMER_W'(TXACK_TIMEOUT_US);
          run_n   = 1'b1;
          state_n = C_WAIT_TXACK;
        end else begin
          state_n = C_ISSUE;
        end
      end
      C_WAIT_TXACK: begin
        // A dropped send (RX start raced it) ends here via the timeout.
        if (bus.tx_errd_i || expired_s) begin
          run_n   = 1'b0;
          state_n = C_RETRY;
        end else if (bus.tx_acked_i) begin
          timer_n = TIMER_W'(RESP_TIMEOUT_US);
          run_n   = 1'b1;
          state_n = C_WAIT_RESP;
        end else begin
          state_n = C_WAIT_TXACK;
        end
      end
      C_WAIT_RESP: begin
        if (bus.code_rx_v_i && (bus.code_rx_i == PS2_ACK)) begin
          done_n  = 1'b1;
          run_n   = 1'b0;
          state_n = C_IDLE;
        end else if ((bus.code_rx_v_i && (bus.code_rx_i == PS2_RESEND)) || expired_s) begin
          run_n   = 1'b0;
          state_n = C_RETRY;
        end else begin
          state_n = C_WAIT_RESP;
        end
      end
      C_RETRY: begin
        run_n = 1'b0;
        if (retry_r == RETRY_W'(MAX_RETRY)) begin
          err_n   = 1'b1;
          state_n = C_IDLE;
        end else begin
          retry_n = retry_r + RETRY_W'(1);
          state_n = C_ISSUE;
        end
      end
      default: begin
        run_n   = 1'b0;
        state_n = C_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: FIFO order/overflow, command issue with
// port back-pressure, resend and NACK retries, pass-through bytes and reset.
module tb_ps2_kbd_ctrl;
  logic clk6x = 1'b0;
  logic resetn = 1'b0;
  logic ck1us = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   tx_cnt = 0, done_cnt = 0, err_cnt = 0;

  ps2_kbd_ctrl_if #(.DEPTH_LOG2(4)) bus ();

  ps2_kbd_ctrl #(.DEPTH_LOG2(4), .MAX_RETRY(3)) dut (
    .clk6x  (clk6x),
    .resetn (resetn),
    .ck1us  (ck1us),
    .bus    (bus.slave)
  );

  always #10 clk6x = ~clk6x;

  initial begin
    forever begin
      repeat (47) @(posedge clk6x);
      #1 ck1us = 1'b1;
      @(posedge clk6x);
      #1 ck1us = 1'b0;
    end
  end

  always @(negedge clk6x) begin
    if (bus.cmd_tx_v_o === 1'b1)      tx_cnt++;
    if (bus.host_cmd_done_o === 1'b1) done_cnt++;
    if (bus.host_cmd_err_o === 1'b1)  err_cnt++;
  end

  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.code_rx_i = b;
    bus.code_rx_v_i = 1'b1;
    tick();
    bus.code_rx_v_i = 1'b0;
  endtask

  task automatic pop_one();
    bus.rd_pop_i = 1'b1;
    tick();
    bus.rd_pop_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    bus.host_cmd_i = c;
    bus.host_cmd_v_i = 1'b1;
    tick();
    bus.host_cmd_v_i = 1'b0;
  endtask

  task automatic wait_tx(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.cmd_tx_v_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: cmd_tx_v_o never pulsed within 20 cycles", name);
    end
  endtask

  task automatic ack_line();
    bus.tx_acked_i = 1'b1;
    tick();
    bus.tx_acked_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.cmd_tx_o, bus.cmd_tx_v_o, bus.rd_data_o, bus.fifo_count_o, bus.ovf_o,
         bus.host_cmd_busy_o, bus.host_cmd_done_o, bus.host_cmd_err_o} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got tx=%h v=%b data=%h cnt=%0d ovf=%b busy=%b, expected all 0",
               bus.cmd_tx_o, bus.cmd_tx_v_o, bus.rd_data_o, bus.fifo_count_o, bus.ovf_o, bus.host_cmd_busy_o);
    end
    checks++;
    if (bus.rd_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty: got %b expected 1", bus.rd_empty_o);
    end
  endtask

  task automatic test_fifo_basic();
    logic [7:0] exp_b [3] = '{8'h1C, 8'hF0, 8'h1C};
    for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
    checks++;
    if (bus.fifo_count_o !== 5'd3 || bus.rd_data_o !== 8'h1C) begin
      errors++;
      $display("FAIL fifo_fill: got count=%0d head=%h expected 3 / 1c", bus.fifo_count_o, bus.rd_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.rd_data_o !== exp_b[i]) begin
        errors++;
        $display("FAIL fifo_order%0d: got %h expected %h", i, bus.rd_data_o, exp_b[i]);
      end
      pop_one();
    end
    pop_one();
    checks++;
    if (bus.rd_empty_o !== 1'b1 || bus.rd_data_o !== 8'h00 || bus.fifo_count_o !== 5'd0) begin
      errors++;
      $display("FAIL fifo_drained: got empty=%b data=%h count=%0d expected 1 / 00 / 0",
               bus.rd_empty_o, bus.rd_data_o, bus.fifo_count_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b;
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    checks++;
    if (bus.fifo_count_o !== 5'd16 || bus.ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: got count=%0d ovf=%b expected 16 / 0", bus.fifo_count_o, bus.ovf_o);
    end
    push_byte(8'h20);
    checks++;
    if (bus.fifo_count_o !== 5'd16 || bus.ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_17th: got count=%0d ovf=%b expected 16 / 1", bus.fifo_count_o, bus.ovf_o);
    end
    bus.rd_pop_i = 1'b1;
    push_byte(8'h40);
    bus.rd_pop_i = 1'b0;
    checks++;
    if (bus.fifo_count_o !== 5'd16 || bus.rd_data_o !== 8'h11 || bus.ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pushpop: got count=%0d head=%h ovf=%b expected 16 / 11 / 1",
               bus.fifo_count_o, bus.rd_data_o, bus.ovf_o);
    end
    bus.ovf_clr_i = 1'b1;
    tick();
    bus.ovf_clr_i = 1'b0;
    checks++;
    if (bus.ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", bus.ovf_o);
    end
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'h11 + 8'(i) : 8'h40;
      checks++;
      if (bus.rd_data_o !== exp_b) begin
        errors++;
        $display("FAIL ovf_drain%0d: got %h expected %h", i, bus.rd_data_o, exp_b);
      end
      pop_one();
    end
    checks++;
    if (bus.rd_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain_empty: got %b expected 1", bus.rd_empty_o);
    end
  endtask

  task automatic test_cmd_busy();
    int tx0 = tx_cnt, dn0 = done_cnt;
    bit seen = 1'b0;
    bus.port_busy_i = 1'b1;
    send_cmd(8'hED);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.cmd_tx_v_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || bus.host_cmd_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_holdoff: got pulse=%b busy=%b expected 0 / 1", seen, bus.host_cmd_busy_o);
    end
    bus.port_busy_i = 1'b0;
    wait_tx("busy_release");
    checks++;
    if (bus.cmd_tx_o !== 8'hED) begin
      errors++;
      $display("FAIL busy_cmd_byte: got %h expected ed", bus.cmd_tx_o);
    end
    repeat (5) tick();
    checks++;
    if (tx_cnt - tx0 !== 1) begin
      errors++;
      $display("FAIL busy_single_pulse: got %0d pulses expected 1", tx_cnt - tx0);
    end
    ack_line();
    push_byte(8'hFA);
    checks++;
    if (bus.host_cmd_done_o !== 1'b1 || bus.rd_empty_o !== 1'b1 || bus.host_cmd_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_done: got done=%b empty=%b busy=%b expected 1 / 1 / 0",
               bus.host_cmd_done_o, bus.rd_empty_o, bus.host_cmd_busy_o);
    end
    tick();
    checks++;
    if (done_cnt - dn0 !== 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d expected 1", done_cnt - dn0);
    end
  endtask

  task automatic test_resend();
    int tx0 = tx_cnt, dn0 = done_cnt, er0 = err_cnt;
    send_cmd(8'hFF);
    for (int a = 0; a < 4; a++) begin
      wait_tx("resend_attempt");
      ack_line();
      push_byte((a < 3) ? 8'hFE : 8'hFA);
    end
    repeat (3) tick();
    checks++;
    if (tx_cnt - tx0 !== 4 || done_cnt - dn0 !== 1 || err_cnt - er0 !== 0) begin
      errors++;
      $display("FAIL resend_counts: got tx=%0d done=%0d err=%0d expected 4 / 1 / 0",
               tx_cnt - tx0, done_cnt - dn0, err_cnt - er0);
    end
    checks++;
    if (bus.rd_empty_o !== 1'b1 || bus.cmd_tx_o !== 8'hFF) begin
      errors++;
      $display("FAIL resend_fifo: got empty=%b cmd=%h expected 1 / ff", bus.rd_empty_o, bus.cmd_tx_o);
    end
  endtask

  task automatic test_errd();
    int tx0 = tx_cnt, dn0 = done_cnt, er0 = err_cnt;
    send_cmd(8'hF4);
    for (int a = 0; a < 4; a++) begin
      wait_tx("errd_attempt");
      bus.tx_errd_i = 1'b1;
      bus.tx_acked_i = (a == 1);   // one attempt sees both; the NACK must win
      tick();
      bus.tx_errd_i = 1'b0;
      bus.tx_acked_i = 1'b0;
    end
    tick();
    checks++;
    if (bus.host_cmd_err_o !== 1'b1 || bus.host_cmd_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL errd_final: got err=%b busy=%b expected 1 / 0", bus.host_cmd_err_o, bus.host_cmd_busy_o);
    end
    repeat (25) tick();
    checks++;
    if (tx_cnt - tx0 !== 4 || err_cnt - er0 !== 1 || done_cnt - dn0 !== 0) begin
      errors++;
      $display("FAIL errd_counts: got tx=%0d err=%0d done=%0d expected 4 / 1 / 0",
               tx_cnt - tx0, err_cnt - er0, done_cnt - dn0);
    end
  endtask

  task automatic test_passthrough();
    int dn0 = done_cnt;
    send_cmd(8'hED);
    wait_tx("pass_issue");
    ack_line();
    push_byte(8'h1C);
    send_cmd(8'h11);    // ignored while the engine is busy
    checks++;
    if (bus.fifo_count_o !== 5'd1 || bus.rd_data_o !== 8'h1C || bus.host_cmd_busy_o !== 1'b1
        || bus.cmd_tx_o !== 8'hED) begin
      errors++;
      $display("FAIL pass_queue: got count=%0d head=%h busy=%b cmd=%h expected 1 / 1c / 1 / ed",
               bus.fifo_count_o, bus.rd_data_o, bus.host_cmd_busy_o, bus.cmd_tx_o);
    end
    push_byte(8'hFA);
    checks++;
    if (bus.host_cmd_done_o !== 1'b1 || bus.fifo_count_o !== 5'd1) begin
      errors++;
      $display("FAIL pass_done: got done=%b count=%0d expected 1 / 1", bus.host_cmd_done_o, bus.fifo_count_o);
    end
    pop_one();
    tick();
    checks++;
    if (done_cnt - dn0 !== 1 || bus.rd_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL pass_after: got done=%0d empty=%b expected 1 / 1", done_cnt - dn0, bus.rd_empty_o);
    end
  endtask

  task automatic test_reset_mid();
    int tx0, dn0, er0;
    push_byte(8'h33);
    send_cmd(8'hFF);
    wait_tx("rstmid_issue");
    tick();
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.cmd_tx_o !== 8'h00 || bus.cmd_tx_v_o !== 1'b0 || bus.host_cmd_busy_o !== 1'b0
        || bus.fifo_count_o !== 5'd0 || bus.rd_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: got cmd=%h v=%b busy=%b count=%0d empty=%b expected 00 / 0 / 0 / 0 / 1",
               bus.cmd_tx_o, bus.cmd_tx_v_o, bus.host_cmd_busy_o, bus.fifo_count_o, bus.rd_empty_o);
    end
    tx0 = tx_cnt; dn0 = done_cnt; er0 = err_cnt;
    repeat (3) tick();
    resetn = 1'b1;
    ack_line();
    repeat (30) tick();
    checks++;
    if (tx_cnt - tx0 !== 0 || done_cnt - dn0 !== 0 || err_cnt - er0 !== 0 || bus.host_cmd_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_silent: got tx=%0d done=%0d err=%0d busy=%b expected 0 / 0 / 0 / 0",
               tx_cnt - tx0, done_cnt - dn0, err_cnt - er0, bus.host_cmd_busy_o);
    end
  endtask

  initial begin
    bus.code_rx_i = 8'h00;   bus.code_rx_v_i = 1'b0;
    bus.port_busy_i = 1'b0;  bus.tx_acked_i = 1'b0;  bus.tx_errd_i = 1'b0;
    bus.rd_pop_i = 1'b0;     bus.ovf_clr_i = 1'b0;
    bus.host_cmd_i = 8'h00;  bus.host_cmd_v_i = 1'b0;
    repeat (3) tick();
    test_reset();
    resetn = 1'b1;
    tick();
    test_fifo_basic();
    test_overflow();
    test_cmd_busy();
    test_resend();
    test_errd();
    test_passthrough();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
